mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM pipeline stage between the EX/MEM register and mem_wb.
- Takes the EX/MEM bundle, performs data-memory loads and stores over a variable-latency req/ready bus, and handles byte-lane steering, sign/zero extension and alignment checking.
- Outputs a registered result bundle that drives the mem_wb inputs directly.
- Stalls upstream stages while an access is outstanding.

Parameters:
- MAX_WAIT, 15: cycles in WAIT without dmem_ready before the access aborts with bus_err.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX/MEM bundle holds a real instruction.
- ALUResult  in  32  ALU result / effective address.
- write_data  in  32  store data (rt).
- regdst  in  5  write-register number.
- pc_in  in  32  instruction PC (+4).
- memtoreg  in  2  writeback select, passed through.
- regwrite  in  1  register write enable.
- memread  in  1  load.
- memwrite  in  1  store.
- memsize  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- mem_unsigned  in  1  zero-extend loads (lbu/lhu).
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word-aligned address, {ALUResult[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data, valid when dmem_ready=1.
- dmem_ready  in  1  access complete.
- stall  out  1  upstream must hold its registers.
- out_valid  out  1  output bundle is a real instruction.
- ALUResult_out  out  32  to mem_wb.
- mem_read_out  out  32  extended load data.
- regdst_out  out  5  to mem_wb.
- pc_out  out  32  to mem_wb.
- memtoreg_out  out  2  to mem_wb.
- regwrite_out  out  1  to mem_wb.
- align_err  out  1  one-cycle pulse: misaligned access dropped.
- bus_err  out  1  one-cycle pulse: access timed out.

Behaviour:

Reset:
- Synchronous; state=IDLE, wait counter=0, all outputs 0.
- Reset during WAIT abandons the access; a dmem_ready arriving after reset is ignored.

FSM, IDLE:
- is_mem = in_valid & (memread|memwrite).
- Misaligned: word with addr[1:0]!=0, or half with addr[0]=1.
- In_valid and not a memory op: the next edge registers the bundle, out_valid=1, mem_read_out=0. Latency 1.
- Aligned memory op: combinationally drive dmem_req=1 and stall=1, with dmem_we/addr/be/wdata from the inputs. Capture the bundle; go to WAIT.
- Misaligned memory op: no bus access. Next edge gives out_valid=0, regwrite_out=0, align_err=1 for one cycle; stay IDLE.
- in_valid=0: next edge gives out_valid=0, regwrite_out=0; other output fields hold.

FSM, WAIT:
- dmem_req=1, stall=1 until dmem_ready. Bus signals come from the captured copy and are stable.
- On dmem_ready:
  - stall=0 in that cycle.
  - Next edge loads the outputs from the captured bundle plus extracted rdata, out_valid=1, and returns to IDLE.
  - The edge that leaves WAIT never accepts the inputs as a new op; upstream advances on that same edge.
- Counter increments each WAIT cycle without ready. On reaching MAX_WAIT: dmem_req drops, outputs become a bubble (out_valid=0, regwrite_out=0), bus_err pulses, return to IDLE.

Stall:
- Combinational: stall = (IDLE & aligned mem op) | (WAIT & ~dmem_ready).

Memory ops:
- memread and memwrite both 1: treated as a store; mem_read_out=0.

Lanes (little-endian, lane = addr[1:0]):
- Store byte: be = 4'b0001<<lane, wdata = {4{wd[7:0]}}.
- Store half: be = 4'b0011<<(2*addr[1]), wdata = {2{wd[15:0]}}.
- Store word: be = 4'b1111, wdata = wd.
- Load byte: rdata[8*lane+7 : 8*lane], sign-extended unless mem_unsigned.
- Load half: the selected halfword, same extension rule.
- Load word: raw rdata.
- For loads, dmem_be = 4'b0000 and dmem_we=0.

Outputs and bubbles:
- Stores complete with out_valid=1 and mem_read_out=0; regwrite_out is passed through.
- Whenever out_valid=0, regwrite_out=0, so mem_wb never writes on a bubble.

Test Plan:
- ALU op: ALUResult=0x1234, regdst=5, regwrite=1 → next cycle out_valid=1, ALUResult_out=0x1234, regdst_out=5, stall never 1.
- lb at 0x103, mem_unsigned=0, rdata=0x80FF_0000 with ready after 3 cycles → stall high 4 cycles, mem_read_out=0xFFFF_FF80. Repeat with lbu → 0x0000_0080.
- sh at 0x102, write_data=0xAAAA_BEEF → dmem_addr=0x100, dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1.
- lw at 0x101 → no dmem_req, align_err pulses once, out_valid=0, regwrite_out=0.
- MAX_WAIT=15, dmem_ready held 0 → bus_err pulses after 15 WAIT cycles, dmem_req=0, state returns to IDLE, next ALU op passes in 1 cycle.
- reset asserted mid-WAIT, then a late dmem_ready → all outputs 0, no out_valid pulse, stall=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between the EX/MEM register and mem_wb.
//
// Issues data-memory loads/stores over a variable-latency req/ready bus,
// steers store bytes onto the right lanes, extracts and sign/zero-extends
// load data, rejects misaligned accesses and aborts accesses whose ready
// never arrives. The result bundle is registered and feeds mem_wb directly.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid .. mem_unsigned         EX/MEM bundle (address, store data,
//                                    writeback controls, access type)
//   dmem_req/we/addr/wdata/be        data-memory request (combinational)
//   dmem_rdata, dmem_ready           data-memory response
//   stall                            upstream must hold its registers
//   out_valid .. regwrite_out        registered bundle to mem_wb
//   align_err, bus_err               one-cycle error pulses
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] write_data,
    input  logic [4:0]  regdst,
    input  logic [31:0] pc_in,
    input  logic [1:0]  memtoreg,
    input  logic        regwrite,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  memsize,
    input  logic        mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] ALUResult_out,
    output logic [31:0] mem_read_out,
    output logic [4:0]  regdst_out,
    output logic [31:0] pc_out,
    output logic [1:0]  memtoreg_out,
    output logic        regwrite_out,
    output logic        align_err,
    output logic        bus_err
);
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b10:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b10:   store_be = 4'b0001 << lane;
            2'b01:   store_be = 4'b0011 << {lane[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b10:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                                 input logic uns, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b10:   load_extract = {{24{b[7] & ~uns}}, b};
            2'b01:   load_extract = {{16{h[15] & ~uns}}, h};
            default: load_extract = rd;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        ov_q, ov_d, rw_q, rw_d, aerr_q, aerr_d, berr_q, berr_d;
    logic [31:0] alu_q, alu_d, mrd_q, mrd_d, pc_q, pc_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  m2r_q, m2r_d;

    // Copy of the accepted access; upstream may change its outputs while we wait.
    logic [31:0] cap_addr_q, cap_wd_q, cap_pc_q;
    logic [4:0]  cap_rd_q;
    logic [1:0]  cap_m2r_q, cap_size_q;
    logic        cap_rw_q, cap_ld_q, cap_we_q, cap_uns_q;

    logic        in_wait, is_mem, misal, issue, bus_on, src_we;
    logic [31:0] src_addr, src_wd;
    logic [1:0]  src_size;

    assign in_wait = (state_q == S_WAIT);
    assign is_mem  = in_valid & (memread | memwrite);
    assign misal   = is_misaligned(memsize, ALUResult[1:0]);
    assign issue   = (state_q == S_IDLE) & is_mem & ~misal;

    // The issue cycle drives the bus from the live inputs, WAIT from the copy.
    assign src_addr = in_wait ? cap_addr_q : ALUResult;
    assign src_wd   = in_wait ? cap_wd_q   : write_data;
    assign src_size = in_wait ? cap_size_q : memsize;
    assign src_we   = in_wait ? cap_we_q   : memwrite;

    // Reset forces every output low, including the combinational bus side.
    assign bus_on     = ~reset & (issue | in_wait);
    assign dmem_req   = bus_on;
    assign dmem_we    = bus_on & src_we;
    assign dmem_addr  = bus_on ? {src_addr[31:2], 2'b00} : 32'h0;
    assign dmem_be    = (bus_on & src_we) ? store_be(src_size, src_addr[1:0]) : 4'b0000;
    assign dmem_wdata = (bus_on & src_we) ? store_data(src_size, src_wd) : 32'h0;
    assign stall      = ~reset & (issue | (in_wait & ~dmem_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = 1'b0;
        rw_d    = 1'b0;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        alu_d   = alu_q;
        mrd_d   = mrd_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        m2r_d   = m2r_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (in_valid && !(memread || memwrite)) begin
                    ov_d  = 1'b1;
                    rw_d  = regwrite;
                    alu_d = ALUResult;
                    mrd_d = 32'h0;
                    rd_d  = regdst;
                    pc_d  = pc_in;
                    m2r_d = memtoreg;
                end else if (is_mem && misal) begin
                    aerr_d = 1'b1;
                end else if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ov_d    = 1'b1;
                    rw_d    = cap_rw_q;
                    alu_d   = cap_addr_q;
                    mrd_d   = cap_ld_q ? load_extract(cap_size_q, cap_addr_q[1:0], cap_uns_q, dmem_rdata)
                                       : 32'h0;
                    rd_d    = cap_rd_q;
                    pc_d    = cap_pc_q;
                    m2r_d   = cap_m2r_q;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    // Timed out: drop the access and emit a bubble.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            rw_q    <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
            alu_q   <= 32'h0;
            mrd_q   <= 32'h0;
            rd_q    <= 5'h0;
            pc_q    <= 32'h0;
            m2r_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            rw_q    <= rw_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
            alu_q   <= alu_d;
            mrd_q   <= mrd_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            m2r_q   <= m2r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            cap_addr_q <= ALUResult;
            cap_wd_q   <= write_data;
            cap_pc_q   <= pc_in;
            cap_rd_q   <= regdst;
            cap_m2r_q  <= memtoreg;
            cap_size_q <= memsize;
            cap_rw_q   <= regwrite;
            cap_ld_q   <= memread & ~memwrite;  // read+write is a store
            cap_we_q   <= memwrite;
            cap_uns_q  <= mem_unsigned;
        end
    end

    assign out_valid     = ov_q;
    assign ALUResult_out = alu_q;
    assign mem_read_out  = mrd_q;
    assign regdst_out    = rd_q;
    assign pc_out        = pc_q;
    assign memtoreg_out  = m2r_q;
    assign regwrite_out  = rw_q;
    assign align_err     = aerr_q;
    assign bus_err       = berr_q;

endmodule
